// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the two-client burst arbiter in front of the
// 4K x 32 feature/weight RAM.
package ram_arb_pkg;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int LEN_W    = 8;
  localparam int N_CLIENT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } burst_cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: one-hot winner from the request pair, with the
// priority pointer flipping each time a grant is actually taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] win
);

  logic rr_q, rr_d;

  always_comb begin
    rr_d = take ? ~rr_q : rr_q;
    unique case (req)
      2'b11:   win = rr_q ? 2'b10 : 2'b01;
      default: win = req;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end

endmodule

// File: rtl/ram_arbiter_4kx32.sv
// Burst arbiter and address sequencer for the shared 4K x 32 RAM: client 0 is
// the DMA loader, client 1 the convolution engine.
module ram_arbiter_4kx32
  import ram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_0,
  input  logic              we_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [LEN_W-1:0]  len_0,
  input  logic [DATA_W-1:0] wdata_0,
  output logic              gnt_0,
  output logic              beat_0,
  output logic              rvalid_0,
  output logic              done_0,
  input  logic              req_1,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [LEN_W-1:0]  len_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_1,
  output logic              beat_1,
  output logic              rvalid_1,
  output logic              done_1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_data_i,
  input  logic [DATA_W-1:0] ram_data_o
);

  arb_state_t          state_q, state_d;
  burst_cmd_t          cmd_q, cmd_d, cmd_0, cmd_1;
  logic [N_CLIENT-1:0] req_v, win, take_v;
  logic [N_CLIENT-1:0] gnt_q, gnt_d, rvalid_q, rvalid_d, done_q, done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                take, in_burst;

  assign req_v  = {req_1, req_0};
  assign cmd_0  = '{we: we_0, addr: addr_0, len: len_0};
  assign cmd_1  = '{we: we_1, addr: addr_1, len: len_1};
  assign take_v = win;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (req_v),
    .take (take),
    .win  (win)
  );

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    gnt_d    = gnt_q;
    rdata_d  = rdata_q;
    rvalid_d = '0;
    done_d   = '0;
    take     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_v) begin
          take    = 1'b1;
          gnt_d   = take_v;
          cmd_d   = take_v[1] ? cmd_1 : cmd_0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (!cmd_q.we) begin
          rdata_d  = ram_data_o;
          rvalid_d = gnt_q;
        end
        cmd_d.addr = cmd_q.addr + ADDR_W'(1);
        cmd_d.len  = cmd_q.len - LEN_W'(1);
        // len counts down to zero on the last beat; grant drops entering DONE
        if (cmd_q.len == '0) begin
          state_d = DONE;
          gnt_d   = '0;
          done_d  = gnt_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
    end
  end

  assign in_burst   = (state_q == BURST);
  assign ram_addr   = in_burst ? cmd_q.addr : '0;
  assign ram_we     = in_burst & cmd_q.we;
  assign ram_data_i = ram_we ? (gnt_q[1] ? wdata_1 : wdata_0) : '0;

  assign gnt_0    = gnt_q[0];
  assign gnt_1    = gnt_q[1];
  assign beat_0   = in_burst & gnt_q[0];
  assign beat_1   = in_burst & gnt_q[1];
  assign rvalid_0 = rvalid_q[0];
  assign rvalid_1 = rvalid_q[1];
  assign done_0   = done_q[0];
  assign done_1   = done_q[1];
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_ram_arbiter_4kx32.sv
// Bench for ram_arbiter_4kx32: behavioural RAM, transaction-level memory and
// round-robin model, directed table plus randomized bursts.
module tb_ram_arbiter_4kx32;
  import ram_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              req_0 = 0, we_0 = 0, req_1 = 0, we_1 = 0;
  logic [ADDR_W-1:0] addr_0 = '0, addr_1 = '0;
  logic [LEN_W-1:0]  len_0 = '0, len_1 = '0;
  logic [DATA_W-1:0] wdata_0 = '0, wdata_1 = '0;
  logic              gnt_0, beat_0, rvalid_0, done_0;
  logic              gnt_1, beat_1, rvalid_1, done_1;
  logic [DATA_W-1:0] rdata, ram_data_i, ram_data_o;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;

  ram_arbiter_4kx32 dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .len_0(len_0), .wdata_0(wdata_0),
    .gnt_0(gnt_0), .beat_0(beat_0), .rvalid_0(rvalid_0), .done_0(done_0),
    .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .len_1(len_1), .wdata_1(wdata_1),
    .gnt_1(gnt_1), .beat_1(beat_1), .rvalid_1(rvalid_1), .done_1(done_1),
    .rdata(rdata), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_data_i(ram_data_i), .ram_data_o(ram_data_o)
  );

  // RAM with combinational read, as the block sees it in the system
  logic [DATA_W-1:0] mem [0:4095];
  assign ram_data_o = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_data_i;

  logic [DATA_W-1:0] ref_mem [0:4095];
  logic model_rr;
  int total = 0;
  int bad = 0;

  typedef struct {
    int          c;
    logic        we;
    logic [11:0] addr;
    logic [7:0]  len;
    logic [31:0] dbase;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;
  vec_t tbl [7];

  function automatic logic [31:0] init_word(int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive_req(input int c, input logic r, input logic w,
                           input logic [11:0] a, input logic [7:0] l);
    if (c == 0) begin req_0 = r; we_0 = w; addr_0 = a; len_0 = l; end
    else        begin req_1 = r; we_1 = w; addr_1 = a; len_1 = l; end
  endtask

  task automatic drop_req(input int c);
    if (c == 0) req_0 = 1'b0; else req_1 = 1'b0;
  endtask

  task automatic set_wdata(input int c, input logic [31:0] d);
    if (c == 0) wdata_0 = d; else wdata_1 = d;
  endtask

  // {gnt, beat, rvalid, done} of one client
  function automatic logic [3:0] outs(input int c);
    return (c == 0) ? {gnt_0, beat_0, rvalid_0, done_0} : {gnt_1, beat_1, rvalid_1, done_1};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_rr = 1'b0;
  endtask

  // One uncontested burst, entered and left in an IDLE cycle (1ns after the edge)
  task automatic do_burst(input int c, input logic w, input logic [11:0] a,
                          input logic [7:0] l, input logic [31:0] dbase,
                          output logic [31:0] first, output logic [31:0] last);
    int          n;
    logic [11:0] ad, pa, la;
    logic [3:0]  s, so;
    n = int'(l) + 1;
    first = '0;
    last  = '0;
    drive_req(c, 1'b1, w, a, l);
    @(posedge clk); #1;
    s = outs(c);
    chk("gnt_latency", 32'(s[3]), 1);
    drop_req(c);
    if (!s[3]) return;
    model_rr = ~model_rr;
    for (int i = 0; i < n; i++) begin
      ad = a + 12'(i);
      pa = ad - 12'd1;
      if (w) set_wdata(c, dbase + 32'(i));
      #1;
      s  = outs(c);
      so = outs(1 - c);
      chk("beat", 32'(s[2]), 1);
      chk("other_quiet", 32'(so), 0);
      chk("ram_addr", 32'(ram_addr), 32'(ad));
      chk("ram_we", 32'(ram_we), 32'(w));
      if (w) chk("ram_data_i", ram_data_i, dbase + 32'(i));
      chk("rvalid", 32'(s[1]), 32'(!w && i > 0));
      if (!w && i > 0) begin
        chk("rdata", rdata, ref_mem[pa]);
        if (i == 1) first = rdata;
      end
      if (w) ref_mem[ad] = dbase + 32'(i);
      @(posedge clk); #1;
    end
    s  = outs(c);
    la = a + 12'(l);
    chk("done", 32'(s[0]), 1);
    chk("gnt_dropped", 32'(s[3]), 0);
    chk("done_ram_we", 32'(ram_we), 0);
    chk("done_ram_addr", 32'(ram_addr), 0);
    if (!w) begin
      chk("rvalid_last", 32'(s[1]), 1);
      chk("rdata_last", rdata, ref_mem[la]);
      last = rdata;
      if (n == 1) first = rdata;
    end
    @(posedge clk); #1;
    chk("idle_quiet", 32'(outs(c)), 0);
  endtask

  // Both clients request reads together; the model pointer names the winner
  task automatic contested(input logic [7:0] l0, input logic [7:0] l1);
    int         cnt, wc;
    logic [3:0] s;
    drive_req(0, 1'b1, 1'b0, 12'($urandom), l0);
    drive_req(1, 1'b1, 1'b0, 12'($urandom), l1);
    @(posedge clk); #1;
    wc = model_rr ? 1 : 0;
    chk("tie_gnt_0", 32'(gnt_0), 32'(wc == 0));
    chk("tie_gnt_1", 32'(gnt_1), 32'(wc == 1));
    model_rr = ~model_rr;
    drop_req(0);
    drop_req(1);
    cnt = 0;
    while (!(done_0 || done_1) && cnt < 300) begin
      @(posedge clk); #1;
      cnt++;
    end
    s = outs(wc);
    chk("tie_done", 32'(s[0]), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] f, l;
    int          cyc, ngr, last_beat;
    int          gcnt [2];
    int          dcnt [2];
    int          order [$];
    logic [1:0]  prev_gnt;

    for (int i = 0; i < 4096; i++) begin
      mem[i]     = init_word(i);
      ref_mem[i] = init_word(i);
    end
    model_rr = 1'b0;

    tbl[0] = '{0, 1'b1, 12'd5,    8'd3, 32'd233,  32'd0,    32'd0};
    tbl[1] = '{1, 1'b0, 12'd5,    8'd3, 32'd0,    32'd233,  32'd236};
    tbl[2] = '{0, 1'b1, 12'd4094, 8'd3, 32'd1000, 32'd0,    32'd0};
    tbl[3] = '{1, 1'b0, 12'd0,    8'd0, 32'd0,    32'd1002, 32'd1002};
    tbl[4] = '{0, 1'b0, 12'd4094, 8'd3, 32'd0,    32'd1000, 32'd1003};
    tbl[5] = '{1, 1'b1, 12'd100,  8'd0, 32'd77,   32'd0,    32'd0};
    tbl[6] = '{0, 1'b0, 12'd100,  8'd0, 32'd0,    32'd77,   32'd77};

    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_handshake", {24'd0, outs(1), outs(0)}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_data_i", ram_data_i, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // directed table
    for (int k = 0; k < 7; k++) begin
      do_burst(tbl[k].c, tbl[k].we, tbl[k].addr, tbl[k].len, tbl[k].dbase, f, l);
      if (!tbl[k].we) begin
        chk($sformatf("tbl%0d_first", k), f, tbl[k].exp_first);
        chk($sformatf("tbl%0d_last", k), l, tbl[k].exp_last);
      end
    end

    // tie right after reset: client 0 first, client 1 follows holding req
    do_reset();
    drive_req(0, 1'b1, 1'b0, 12'd5, 8'd1);
    drive_req(1, 1'b1, 1'b0, 12'd100, 8'd0);
    @(posedge clk); #1;
    chk("tie0_gnt_0", 32'(gnt_0), 1);
    chk("tie0_gnt_1", 32'(gnt_1), 0);
    drop_req(0);
    cyc = 0;
    while (!gnt_1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      chk("tie0_onehot", 32'(gnt_0 & gnt_1), 0);
    end
    chk("tie0_handover_cycles", 32'(cyc), 4);
    chk("tie0_gnt_0_low", 32'(gnt_0), 0);
    drop_req(1);
    @(posedge clk); #1;
    chk("tie0_done_1", 32'(done_1), 1);
    chk("tie0_rdata_1", rdata, ref_mem[100]);
    @(posedge clk); #1;

    // reset on the 3rd beat of an 8-word write
    do_reset();
    drive_req(0, 1'b1, 1'b1, 12'd200, 8'd7);
    @(posedge clk); #1;
    chk("mid_gnt", 32'(gnt_0), 1);
    drop_req(0);
    for (int i = 0; i < 3; i++) begin
      set_wdata(0, 32'd500 + 32'(i));
      if (i == 2) rst = 1'b1;
      @(posedge clk); #1;
    end
    chk("mid_ram_we", 32'(ram_we), 0);
    chk("mid_handshake", {24'd0, outs(1), outs(0)}, 0);
    rst = 1'b0;
    model_rr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < 3) ref_mem[200 + i] = 32'd500 + 32'(i);
      chk($sformatf("mid_mem%0d", i), mem[200 + i], (i < 3) ? 32'd500 + 32'(i) : init_word(200 + i));
    end
    @(posedge clk); #1;

    // randomized mix of single-client bursts and ties
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0)
        contested(8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)));
      else
        do_burst(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 12'($urandom), 8'($urandom_range(0, 9)), $urandom, f, l);
    end

    // persistent requests from both sides: strict alternation, N/(N+2) cadence
    do_reset();
    drive_req(0, 1'b1, 1'b0, 12'd40, 8'd2);
    drive_req(1, 1'b1, 1'b0, 12'd4093, 8'd1);
    ngr = 0;
    last_beat = -100;
    gcnt = '{0, 0};
    dcnt = '{0, 0};
    prev_gnt = 2'b00;
    cyc = 0;
    while (cyc < 600 && !(ngr >= 10 && prev_gnt == 2'b00 && cyc > last_beat + 3)) begin
      @(posedge clk); #1;
      cyc++;
      chk("persist_onehot", 32'(gnt_0 & gnt_1), 0);
      for (int c = 0; c < 2; c++) begin
        if (outs(c)[3] && !prev_gnt[c]) begin
          order.push_back(c);
          gcnt[c]++;
          ngr++;
          chk("persist_gap", 32'(cyc - last_beat), (ngr == 1) ? 32'(cyc + 100) : 32'd3);
          if (ngr == 10) begin
            drop_req(0);
            drop_req(1);
          end
        end
        if (outs(c)[0]) dcnt[c]++;
      end
      if (beat_0 || beat_1) last_beat = cyc;
      prev_gnt = {gnt_1, gnt_0};
    end
    chk("persist_grants", 32'(ngr), 10);
    for (int i = 0; i < order.size(); i++)
      chk($sformatf("persist_order%0d", i), 32'(order[i]), 32'(i % 2));
    chk("persist_done_0", 32'(dcnt[0]), 32'(gcnt[0]));
    chk("persist_done_1", 32'(dcnt[1]), 32'(gcnt[1]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/ram_arbiter_4kx32.md
# ram_arbiter_4kx32

Burst-oriented two-client arbiter and address sequencer for the shared 4K x 32 feature/weight RAM (`ram_4kx32_sim` in simulation, distributed RAM with combinational read in synthesis). Client 0 is the DMA loader and client 1 is the convolution engine. Each client requests a burst of 1..256 words, to read or write, from a base address. The arbiter grants one client at a time with round-robin fairness, generates incrementing RAM addresses, and returns registered read data.

## Interface
- `ADDR_W`, 12: RAM address width (4096 words).
- `DATA_W`, 32: RAM data width.
- `LEN_W`, 8: burst length field; burst words = `len` + 1.
- `clk`  in  1: single clock; all logic rises on its positive edge.
- `rst`  in  1: reset, synchronous, active-high.
- `req_c`  in  1: burst request from client c (c = 0, 1). Hold it high until `gnt_c` rises.
- `we_c`  in  1: 1 = write burst, 0 = read burst; sampled with `req_c`.
- `addr_c`  in  ADDR_W: burst base address; sampled with `req_c`.
- `len_c`  in  LEN_W: burst length minus 1; sampled with `req_c`.
- `wdata_c`  in  DATA_W: write data for the current beat.
- `gnt_c`  out  1: high for the whole burst of client c.
- `beat_c`  out  1: a RAM access is issued for client c this cycle; on a write, `wdata_c` is consumed this cycle.
- `rvalid_c`  out  1: `rdata` holds a read word for client c.
- `done_c`  out  1: one-cycle pulse after the burst's last beat.
- `rdata`  out  DATA_W: registered read data, shared by both clients.
- `ram_addr`  out  ADDR_W: to RAM `addr`.
- `ram_we`  out  1: to RAM `we`.
- `ram_data_i`  out  DATA_W: to RAM `data_i`.
- `ram_data_o`  in  DATA_W: from RAM `data_o`; combinational read of `ram_addr`.

## Operation
- States:
  - IDLE: sample requests.
  - BURST: issue one beat per cycle.
  - DONE: pulse `done_c`, deliver the final read word, drop the grant; always returns to IDLE.
- IDLE -> BURST when any `req_c` is high. The winner's `we`, `addr` and `len` are latched into `cur_we`, `cur_addr` and `remain`. `gnt_c` is registered and is high from the first BURST cycle.
- Arbitration:
  - Exactly one request: that client wins.
  - Both requests: the client named by the round-robin pointer `rr` wins.
  - `rr` switches to the other client whenever a grant is issued.
  - `rr` resets to 0, so client 0 wins the first tie.
- BURST, every cycle:
  - `ram_addr` = `cur_addr` and `beat_c` = 1.
  - Write burst: `ram_we` = 1 and `ram_data_i` = `wdata` of the granted client (mux by grant, not by request).
  - Read burst: `ram_data_o` is registered into `rdata`, and `rvalid_c` goes high the next cycle.
  - `cur_addr` increments modulo 4096 (4095 -> 0 wraps silently); `remain` decrements.
  - When `remain` = 0 in a cycle, that cycle is the last beat; next state is DONE.
- `req`, `we`, `addr` and `len` changes during BURST or DONE are ignored. A request that is still high in IDLE is re-arbitrated.
- The non-granted client sees `gnt`, `beat`, `rvalid` and `done` all at 0.
- Outside BURST: `ram_we` = 0; `ram_addr` and `ram_data_i` hold 0.

## Timing
- Reset values: state IDLE, `rr` = 0, every `gnt`/`beat`/`rvalid`/`done` = 0, `rdata` = 0, `ram_we` = 0, `ram_addr` = 0, `ram_data_i` = 0.
- Reset asserted mid-burst: at the next edge, all outputs take their reset values, `ram_we` falls, and the burst is abandoned with no `done`.
- Request to first beat is 1 cycle: `req` seen high in IDLE at edge k gives beat 0 in cycle k+1.
- A burst of N words occupies N BURST cycles, then 1 DONE cycle, then 1 IDLE cycle.
- Bus efficiency: back-to-back bursts run at N / (N + 2).
- Read latency is 1 cycle. The word for beat i appears with `rvalid` in cycle beat_i + 1, so the last word coincides with `done`.
- A write of beat i lands in RAM at the end of beat cycle i. A read issued by another burst later sees that data.

## Structure
- Package `ram_arb_pkg` holds:
  - constants `ADDR_W`, `DATA_W`, `LEN_W`, `N_CLIENT` = 2;
  - the typedef `arb_state_t` enum {IDLE, BURST, DONE};
  - the struct `burst_cmd_t` {we, addr, len}.
- Sub-module `rr_arb2` holds the 2-way round-robin pick (request vector plus `rr`, giving a one-hot winner). It contains the `rr` register, which updates only on grant.
- The RAM itself is instantiated outside, at the level that holds this block.

## Test plan
- Single write: client 0 writes `len` = 3 from address 5 with data 233, 234, 235, 236. Then client 1 reads the same range. Required: `rdata` = 233..236 with `rvalid_1`, and `done_1` on the 236 cycle.
- Simultaneous requests right after reset: client 0 granted first. Client 1 then gets the following grant, having kept `req` high throughout. Required: `rr` alternates, no beat overlap, exactly one `gnt` high at any time.
- Wrap-around: write from address 4094 with `len` = 3. Required: `ram_addr` sequence is 4094, 4095, 0, 1; reading address 0 returns the third word.
- Reset mid-burst: assert `rst` on the 3rd beat of an 8-word write. Required: the next cycle has `ram_we` = 0, all grants 0 and no `done`. Words 0..2 are present in RAM and words 3..7 are unwritten.
- Single-word burst (`len` = 0), read: exactly one `beat`, and `rvalid` coincides with `done`. The next grant can be issued no earlier than 2 cycles after the beat.
- Persistent requests from both clients for 10 bursts: the grant order is 0, 1, 0, 1, …, and every burst's `done` count equals its grant count.
